// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for the frequency meter.
//   state_t    - measurement FSM states
//   SIM_GATE   - gate window for simulation-scale runs (iCLK_50 cycles)
//   HW_GATE    - gate window for a 1 s hardware window at 50 MHz
//   cnt_width  - counter width needed to hold 0..n-1
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int SIM_GATE = 25000;
    localparam int HW_GATE  = 50000000;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: control/result bundle of the frequency meter.
//   en         - measurement enable (synchronous to iCLK_50)
//   sig_in     - signal under measurement (asynchronous)
//   freq       - rising-edge count of the last completed window
//   freq_valid - one-cycle strobe, freq updates in the same cycle
//   overflow   - last completed window saturated the edge counter
// master: the side that drives en/sig_in and consumes results.
// slave : the meter itself.
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq;
    logic             freq_valid;
    logic             overflow;

    modport master (output en, sig_in, input  freq, freq_valid, overflow);
    modport slave  (input  en, sig_in, output freq, freq_valid, overflow);
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer followed by a rising-edge detector.
//   iCLK_50 - sampling clock
//   rst     - asynchronous active-low reset, clears all flops
//   d       - asynchronous input
//   rise    - high for one cycle per synchronized rising edge of d
// rise appears 2-3 cycles after the pin transition.
module sync_edge_det (
    input  logic iCLK_50,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge iCLK_50 or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of bus.sig_in over back-to-back gate
// windows of GATE_CYCLES iCLK_50 cycles and publishes the count.
//   iCLK_50 - 50 MHz system clock
//   rst     - asynchronous active-low reset
//   bus     - freq_meter_if slave: en, sig_in in; freq, freq_valid, overflow out
// The result of a window is staged for one cycle and published on the
// following edge, so the first strobe lands GATE_CYCLES+1 cycles after the
// edge that samples en=1 in IDLE, then every GATE_CYCLES cycles.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = SIM_GATE,
    parameter int CNT_W       = 32
) (
    input  logic         iCLK_50,
    input  logic         rst,
    freq_meter_if.slave  bus
);
    localparam int               GW        = cnt_width(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_w;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ovf;
    logic             res_vld;
    logic [CNT_W-1:0] freq_q;
    logic             freq_valid_q;
    logic             overflow_q;
    logic             rise;
    logic             sat_hit;
    logic [CNT_W-1:0] cnt_next;

    sync_edge_det u_sync (
        .iCLK_50 (iCLK_50),
        .rst     (rst),
        .d       (bus.sig_in),
        .rise    (rise)
    );

    // Saturating count including this cycle's edge; used both for the
    // running count and for the closing value so a final-cycle edge lands
    // in the window that is ending.
    assign sat_hit  = rise && (edge_cnt == CNT_MAX);
    assign cnt_next = (rise && !sat_hit) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge iCLK_50 or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            ovf_w        <= 1'b0;
            res_cnt      <= '0;
            res_ovf      <= 1'b0;
            res_vld      <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            res_vld      <= 1'b0;
            // Publish a staged result only while still measuring, so the
            // strobe never shows up in IDLE or after en drops.
            if (res_vld && state == MEASURE && bus.en) begin
                freq_q       <= res_cnt;
                overflow_q   <= res_ovf;
                freq_valid_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf_w    <= 1'b0;
                    if (bus.en) state <= MEASURE;
                end
                MEASURE: begin
                    if (!bus.en) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_w    <= 1'b0;
                    end else if (gate_cnt == GATE_LAST) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_w    <= 1'b0;
                        res_cnt  <= cnt_next;
                        res_ovf  <= ovf_w | sat_hit;
                        res_vld  <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= cnt_next;
                        ovf_w    <= ovf_w | sat_hit;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.freq       = freq_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.overflow   = overflow_q;
endmodule
